id_hazard_fwd_unit: RTL
=======================

Name: id_hazard_fwd_unit

Overview:
- Parametrised successor to the ID-stage bypass/interlock logic.
- Selects forwarded operands for rs/rt from a configurable number of downstream producer stages.
- Generates load-use and not-ready stalls, and interlocks a multi-cycle MUL/DIV unit through an internal busy counter.
- Keeps a saturating stall-cycle counter for performance debug.
- Sits between the register file read ports and the ID/EX pipeline register.

Parameters:
DATA_W, 32, operand/data width
RA_W, 5, register address width
FWD_DEPTH, 3, number of producer stages (index 0 = youngest, i.e. EX)
MD_LAT, 4, MUL/DIV occupancy in cycles (≥1)
CNT_W, 16, stall counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  instruction present in ID
flush  in  1  kill ID instruction this cycle (taken branch/jump)
rs  in  RA_W  source A address
rt  in  RA_W  source B address
use_rs  in  1  instruction reads rs
use_rt  in  1  instruction reads rt
is_md  in  1  instruction issues MUL/DIV
md_read  in  1  instruction reads MUL/DIV result (mfhi/mflo class)
rf_a  in  DATA_W  register file rs data
rf_b  in  DATA_W  register file rt data
wr_en  in  FWD_DEPTH  stage k writes a register
wr_addr  in  FWD_DEPTH*RA_W  dest of stage k, slice [k*RA_W +: RA_W]
wr_ready  in  FWD_DEPTH  stage k data valid in wr_data (0 = load in EX, etc.)
wr_data  in  FWD_DEPTH*DATA_W  forwardable value of stage k
a_out  out  DATA_W  forwarded rs operand
b_out  out  DATA_W  forwarded rt operand
stall  out  1  hold PC and IF/ID
id_fire  out  1  instruction advances into EX this cycle
md_busy  out  1  MUL/DIV occupied
md_done  out  1  one-cycle pulse when MUL/DIV completes
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high, sampled on the rising edge of `clock`.
- Reset values: md counter 0, md_busy 0, md_done 0, stall_count 0. Combinational outputs follow their inputs.
- Operand match for stage k: wr_en[k] & (wr_addr_k != 0) & (wr_addr_k == rs).
  - Lowest matching k wins (youngest producer).
  - No match: a_out = rf_a. Same rules for rt → b_out / rf_b.
  - Register 0 never forwards and never stalls.
- Data hazard, combinational:
  - haz_a = use_rs & the winning match for rs has wr_ready[k]=0; haz_b likewise for rt/use_rt.
  - An older ready match is NOT used when a younger not-ready match exists.
- MUL/DIV hazard: md_haz = md_busy & (is_md | md_read).
- stall = id_valid & ~flush & (haz_a | haz_b | md_haz).
- id_fire = id_valid & ~flush & ~stall.
  - flush with a hazard: stall=0, id_fire=0.
- MUL/DIV counter:
  - On id_fire & is_md, load MD_LAT.
  - Otherwise, when nonzero, decrement by 1.
  - md_busy = (counter != 0), registered.
  - md_done is registered to 1 in the cycle after the counter transitions 1→0; it is high for exactly one cycle.
  - Back-to-back is_md stalls until md_busy=0. An is_md firing in the same cycle as md_done is legal and reloads the counter.
  - MD_LAT=1 gives md_busy high for one cycle.
- stall_count increments by 1 on each cycle with stall=1 and saturates at all-ones (no wrap).
- Reset mid-MUL/DIV: counter cleared immediately, md_busy 0 next cycle, no md_done pulse.
- Latency: forwarding and stall are zero-cycle (same cycle as inputs). md_busy, md_done and stall_count are one-cycle registered.

Test Plan:
- EX writes r3 (wr_en[0]=1, ready=1, data=0x11), ME writes r3 (data=0x22), instruction uses rs=3 → a_out=0x11, stall=0, id_fire=1.
- EX load to r5 (ready[0]=0), instruction uses rt=5 → stall=1 for that cycle, stall_count increments to 1. Next cycle: the value arrives from ME (index 1) with ready=1 → b_out=ME data, stall=0.
- rs=0 with wr_en[0]=1, wr_addr=0, data=0xFFFF → a_out=rf_a, stall=0 even with ready=0.
- MD_LAT=4: fire is_md at cycle t.
  - md_busy=1 for cycles t+1..t+4, md_done=1 at t+5.
  - A second is_md presented at t+1..t+4 gives stall=1.
  - It fires at t+5 and the counter reloads.
- Load-use hazard with flush=1 → stall=0, id_fire=0, stall_count unchanged.
- Assert reset at cycle t+2 of a MUL/DIV → md_busy=0 at t+3, no md_done pulse; stall_count driven to all-ones stays at all-ones.

Source files
------------

// File: rtl/id_hazard_fwd_unit.sv
// id_hazard_fwd_unit
// ID-stage operand bypass and interlock unit.
//   - Picks the rs/rt operands from the youngest matching producer stage,
//     or from the register file when no stage matches.
//   - Raises stall on a not-ready producer (load-use) or a busy MUL/DIV unit.
//   - Tracks MUL/DIV occupancy with a down-counter and a done pulse.
//   - Keeps a saturating count of stall cycles for performance debug.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   id_valid, flush         ID instruction present / killed this cycle
//   rs, rt, use_rs, use_rt  source addresses and read enables
//   is_md, md_read          issues MUL/DIV / reads the MUL/DIV result
//   rf_a, rf_b              register file read data
//   wr_en, wr_addr,
//   wr_ready, wr_data       per-stage producer info, index 0 = youngest (EX)
//   a_out, b_out            forwarded operands
//   stall, id_fire          interlock and advance
//   md_busy, md_done        MUL/DIV occupancy and completion pulse
//   stall_count             saturating stall-cycle counter
module id_hazard_fwd_unit #(
  parameter int DATA_W    = 32,
  parameter int RA_W      = 5,
  parameter int FWD_DEPTH = 3,
  parameter int MD_LAT    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic                      flush,
  input  logic [RA_W-1:0]           rs,
  input  logic [RA_W-1:0]           rt,
  input  logic                      use_rs,
  input  logic                      use_rt,
  input  logic                      is_md,
  input  logic                      md_read,
  input  logic [DATA_W-1:0]         rf_a,
  input  logic [DATA_W-1:0]         rf_b,
  input  logic [FWD_DEPTH-1:0]      wr_en,
  input  logic [FWD_DEPTH*RA_W-1:0] wr_addr,
  input  logic [FWD_DEPTH-1:0]      wr_ready,
  input  logic [FWD_DEPTH*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]         a_out,
  output logic [DATA_W-1:0]         b_out,
  output logic                      stall,
  output logic                      id_fire,
  output logic                      md_busy,
  output logic                      md_done,
  output logic [CNT_W-1:0]          stall_count
);

  localparam int MD_W = $clog2(MD_LAT + 1);

  logic [MD_W-1:0] md_cnt;
  logic            a_not_ready;
  logic            b_not_ready;
  logic            haz_a;
  logic            haz_b;
  logic            md_haz;

  // Walk from the oldest stage to the youngest so the youngest match is the
  // last assignment and therefore wins, including its ready bit.
  always_comb begin
    a_out       = rf_a;
    b_out       = rf_b;
    a_not_ready = 1'b0;
    b_not_ready = 1'b0;
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (wr_en[k] && (wr_addr[k*RA_W +: RA_W] != '0) &&
          (wr_addr[k*RA_W +: RA_W] == rs)) begin
        a_out       = wr_data[k*DATA_W +: DATA_W];
        a_not_ready = ~wr_ready[k];
      end
      if (wr_en[k] && (wr_addr[k*RA_W +: RA_W] != '0) &&
          (wr_addr[k*RA_W +: RA_W] == rt)) begin
        b_out       = wr_data[k*DATA_W +: DATA_W];
        b_not_ready = ~wr_ready[k];
      end
    end
  end

  assign haz_a   = use_rs & a_not_ready;
  assign haz_b   = use_rt & b_not_ready;
  assign md_busy = (md_cnt != '0);
  assign md_haz  = md_busy & (is_md | md_read);
  assign stall   = id_valid & ~flush & (haz_a | haz_b | md_haz);
  assign id_fire = id_valid & ~flush & ~stall;

  // A new MUL/DIV can only fire when the counter is already zero, so the
  // reload never collides with the 1->0 step that produces md_done.
  always_ff @(posedge clock) begin
    if (reset) begin
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      md_done <= (md_cnt == MD_W'(1));
      if (id_fire && is_md) begin
        md_cnt <= MD_W'(MD_LAT);
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - MD_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
